// File: rtl/vc_port_scheduler_if.sv
// vc_port_scheduler_if
// Bundles the FIFO-side and port-side signals of the VC scheduler.
//   empty_*/data_* : VC FIFO status and read data (FIFO -> scheduler)
//   hold_p0/p1     : downstream stall per port
//   pop_*          : single-cycle pop strobes (scheduler -> FIFO)
//   out/valid/vc   : registered port outputs
//   idle           : all FIFOs empty and nothing in flight
// slave  = scheduler side, master = FIFO/downstream environment side.
interface vc_port_scheduler_if #(
  parameter int DATA_W = 5
);
  logic              empty_VC0P0, empty_VC1P0, empty_VC0P1, empty_VC1P1;
  logic [DATA_W-1:0] data_VC0P0, data_VC1P0, data_VC0P1, data_VC1P1;
  logic              hold_p0, hold_p1;
  logic              pop_VC0P0, pop_VC1P0, pop_VC0P1, pop_VC1P1;
  logic [DATA_W-1:0] out_p0, out_p1;
  logic              valid_p0, valid_p1;
  logic              vc_p0, vc_p1;
  logic              idle;

  modport slave (
    input  empty_VC0P0, empty_VC1P0, empty_VC0P1, empty_VC1P1,
    input  data_VC0P0, data_VC1P0, data_VC0P1, data_VC1P1,
    input  hold_p0, hold_p1,
    output pop_VC0P0, pop_VC1P0, pop_VC0P1, pop_VC1P1,
    output out_p0, out_p1, valid_p0, valid_p1, vc_p0, vc_p1, idle
  );

  modport master (
    output empty_VC0P0, empty_VC1P0, empty_VC0P1, empty_VC1P1,
    output data_VC0P0, data_VC1P0, data_VC0P1, data_VC1P1,
    output hold_p0, hold_p1,
    input  pop_VC0P0, pop_VC1P0, pop_VC0P1, pop_VC1P1,
    input  out_p0, out_p1, valid_p0, valid_p1, vc_p0, vc_p1, idle
  );
endinterface

// File: rtl/vc_port_scheduler.sv
// vc_port_scheduler
// Weighted two-VC scheduler for two independent output ports. Each port
// engine pops one of its two VC FIFOs per cycle (VC0 favoured for up to
// VC0_WEIGHT consecutive grants while VC1 waits) and registers the popped
// word on its port two cycles after the pop.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : vc_port_scheduler_if.slave (FIFO flags/data, holds, pops,
//           port outputs, idle)

// One port engine: arbitration, burst counter and the 2-stage output pipe.
module vc_port_engine #(
  parameter int DATA_W     = 5,
  parameter int VC0_WEIGHT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty_vc0,
  input  logic              empty_vc1,
  input  logic [DATA_W-1:0] data_vc0,
  input  logic [DATA_W-1:0] data_vc1,
  input  logic              hold,
  output logic              pop_vc0,
  output logic              pop_vc1,
  output logic [DATA_W-1:0] out_data,
  output logic              valid,
  output logic              vc,
  output logic              pend
);
  localparam logic [2:0] WEIGHT = 3'(VC0_WEIGHT);

  logic [2:0] burst_cnt;
  logic [2:0] burst_cnt_nxt;
  logic       pend_vc;

  // The counter only accumulates under contention; an uncontended grant
  // to either VC clears it so VC1 always sees a fresh bound.
  always_comb begin
    pop_vc0       = 1'b0;
    pop_vc1       = 1'b0;
    burst_cnt_nxt = burst_cnt;
    if (!reset && !hold) begin
      if (!empty_vc0 && !empty_vc1) begin
        if (burst_cnt < WEIGHT) begin
          pop_vc0       = 1'b1;
          burst_cnt_nxt = burst_cnt + 3'd1;
        end else begin
          pop_vc1       = 1'b1;
          burst_cnt_nxt = '0;
        end
      end else if (!empty_vc0) begin
        pop_vc0       = 1'b1;
        burst_cnt_nxt = '0;
      end else if (!empty_vc1) begin
        pop_vc1       = 1'b1;
        burst_cnt_nxt = '0;
      end
    end
  end

  // FIFO data is valid the cycle after the pop, so the word is captured
  // one cycle after pend is set; out/vc keep their value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
      pend      <= 1'b0;
      pend_vc   <= 1'b0;
      out_data  <= '0;
      valid     <= 1'b0;
      vc        <= 1'b0;
    end else begin
      burst_cnt <= burst_cnt_nxt;
      pend      <= pop_vc0 | pop_vc1;
      pend_vc   <= pop_vc1;
      valid     <= pend;
      if (pend) begin
        out_data <= pend_vc ? data_vc1 : data_vc0;
        vc       <= pend_vc;
      end
    end
  end
endmodule

module vc_port_scheduler #(
  parameter int DATA_W     = 5,
  parameter int VC0_WEIGHT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  vc_port_scheduler_if.slave    bus
);
  logic pend_p0, pend_p1;
  logic all_empty, pop_any;

  vc_port_engine #(.DATA_W(DATA_W), .VC0_WEIGHT(VC0_WEIGHT)) u_port0 (
    .clk       (clk),
    .reset     (reset),
    .empty_vc0 (bus.empty_VC0P0),
    .empty_vc1 (bus.empty_VC1P0),
    .data_vc0  (bus.data_VC0P0),
    .data_vc1  (bus.data_VC1P0),
    .hold      (bus.hold_p0),
    .pop_vc0   (bus.pop_VC0P0),
    .pop_vc1   (bus.pop_VC1P0),
    .out_data  (bus.out_p0),
    .valid     (bus.valid_p0),
    .vc        (bus.vc_p0),
    .pend      (pend_p0)
  );

  vc_port_engine #(.DATA_W(DATA_W), .VC0_WEIGHT(VC0_WEIGHT)) u_port1 (
    .clk       (clk),
    .reset     (reset),
    .empty_vc0 (bus.empty_VC0P1),
    .empty_vc1 (bus.empty_VC1P1),
    .data_vc0  (bus.data_VC0P1),
    .data_vc1  (bus.data_VC1P1),
    .hold      (bus.hold_p1),
    .pop_vc0   (bus.pop_VC0P1),
    .pop_vc1   (bus.pop_VC1P1),
    .out_data  (bus.out_p1),
    .valid     (bus.valid_p1),
    .vc        (bus.vc_p1),
    .pend      (pend_p1)
  );

  assign all_empty = bus.empty_VC0P0 & bus.empty_VC1P0 &
                     bus.empty_VC0P1 & bus.empty_VC1P1;
  assign pop_any   = bus.pop_VC0P0 | bus.pop_VC1P0 |
                     bus.pop_VC0P1 | bus.pop_VC1P1;

  // The only state shared between the two ports.
  always_ff @(posedge clk) begin
    if (reset) bus.idle <= 1'b1;
    else       bus.idle <= all_empty & ~pop_any & ~pend_p0 & ~pend_p1;
  end
endmodule
